// File: rtl/ram_pkg.sv
// Shared types and helpers for ram_n: sweep FSM state encoding and the parity helper.
// The parity helper only exists when RAM_PARITY_EN is defined.
package ram_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    // Widest data word the parity helper accepts; callers zero-extend.
    localparam int PAR_MAXW = 1024;

`ifdef RAM_PARITY_EN
    function automatic logic even_parity(input logic [PAR_MAXW-1:0] d);
        return ^d;
    endfunction
`endif

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer for ram_n: walks every address once writing zero, then idles in READY
// until a clear request restarts the sweep.
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    output logic          sweep_we,
    output logic [AW-1:0] sweep_addr,
    output logic          busy,
    output state_e        state_dbg
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [0:0]    state;
    logic [0:0]    state_nxt;
    logic [AW-1:0] cnt;
    logic [AW-1:0] cnt_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_CLEAR: begin
                if (cnt == LAST) begin
                    state_nxt = ST_READY;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + AW'(1);
                end
            end
            ST_READY: begin
                if (clr) begin
                    state_nxt = ST_CLEAR;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_CLEAR;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign sweep_we   = (state == ST_CLEAR);
    assign sweep_addr = cnt;
    assign busy       = (state == ST_CLEAR);
    assign state_dbg  = state_e'(state);

endmodule

// File: rtl/ram_n.sv
// DEPTH x WIDTH register RAM with registered write-first read and a hardware clear sweep.
// Define RAM_PARITY_EN to store an even-parity bit per word and expose parity_err.
module ram_n
    import ram_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic [AW-1:0]    address,
    input  logic             rd_en,
    input  logic             clr,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             busy
`ifdef RAM_PARITY_EN
    ,
    output logic             parity_err
`endif
);

`ifdef RAM_PARITY_EN
    localparam int MW = WIDTH + 1;
`else
    localparam int MW = WIDTH;
`endif

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic          sweep_we;
    logic [AW-1:0] sweep_addr;
    state_e        seq_state;

    ram_clear_seq #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_clear_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .sweep_we  (sweep_we),
        .sweep_addr(sweep_addr),
        .busy      (busy),
        .state_dbg (seq_state)
    );

    logic [MW-1:0] mem [DEPTH];
    logic [MW-1:0] wr_word;
    logic [MW-1:0] rd_word;
    logic          in_range;
    logic          ready;
    logic          wr_user;
    logic          rd_user;

    // Non-power-of-2 depths leave a tail of address codes that map to no word.
    assign in_range = ({1'b0, address} < DEPTH_W);
    assign ready    = (seq_state == READY);
    assign wr_user  = ready && !clr && load && in_range;
    assign rd_user  = ready && !clr && rd_en;

`ifdef RAM_PARITY_EN
    assign wr_word = {even_parity(PAR_MAXW'(in)), in};
`else
    assign wr_word = in;
`endif

    always_comb begin
        rd_word = '0;
        if (in_range) begin
            rd_word = mem[address];
        end
    end

    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem[sweep_addr] <= '0;
        end else if (wr_user) begin
            mem[address] <= wr_word;
        end
    end

    // Write-first: a read hitting the word being written returns the incoming data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= rd_user;
            if (rd_user) begin
                if (!in_range) begin
                    out <= '0;
                end else if (load) begin
                    out <= in;
                end else begin
                    out <= rd_word[WIDTH-1:0];
                end
            end
        end
    end

`ifdef RAM_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= rd_user && in_range && !load &&
                          (even_parity(PAR_MAXW'(rd_word[WIDTH-1:0])) != rd_word[WIDTH]);
        end
    end
`endif

endmodule

// File: tb/tb_ram_n.sv
// Self-checking bench for ram_n: one DEPTH=8 and one DEPTH=6 instance checked against
// array-based reference models; parity scenario is built when RAM_PARITY_EN is defined.
module tb_ram_n;

    logic clk;
    logic rst_n;

    logic [15:0] in8, out8, in6, out6;
    logic [2:0]  addr8, addr6;
    logic        load8, rd8, clr8, valid8, busy8;
    logic        load6, rd6, clr6, valid6, busy6;
`ifdef RAM_PARITY_EN
    logic        perr8, perr6;
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0] m8 [8];
    logic [15:0] m6 [6];
    logic [15:0] exp_out8, exp_out6;
    logic        exp_v8, exp_v6;

    ram_n #(.WIDTH(16), .DEPTH(8)) d8 (
        .clk(clk), .rst_n(rst_n), .in(in8), .load(load8), .address(addr8),
        .rd_en(rd8), .clr(clr8), .out(out8), .out_valid(valid8), .busy(busy8)
`ifdef RAM_PARITY_EN
        , .parity_err(perr8)
`endif
    );

    ram_n #(.WIDTH(16), .DEPTH(6)) d6 (
        .clk(clk), .rst_n(rst_n), .in(in6), .load(load6), .address(addr6),
        .rd_en(rd6), .clr(clr6), .out(out6), .out_valid(valid6), .busy(busy6)
`ifdef RAM_PARITY_EN
        , .parity_err(perr6)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m8[i] = '0;
        for (int i = 0; i < 6; i++) m6[i] = '0;
        exp_out8 = '0; exp_out6 = '0;
        exp_v8 = 1'b0; exp_v6 = 1'b0;
    endtask

    // One cycle on the DEPTH=8 instance; reference model follows the behavioural rules.
    task automatic op8(input logic ld, input logic rd, input logic cl,
                       input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        load8 = ld; rd8 = rd; clr8 = cl; addr8 = a; in8 = d;
        @(posedge clk); #1;
        load8 = 1'b0; rd8 = 1'b0; clr8 = 1'b0;
        if (cl) begin
            for (int i = 0; i < 8; i++) m8[i] = '0;
            exp_v8 = 1'b0;
        end else begin
            if (ld) m8[a] = d;
            exp_v8 = rd;
            if (rd) exp_out8 = m8[a];
        end
    endtask

    task automatic op6(input logic ld, input logic rd,
                       input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        load6 = ld; rd6 = rd; clr6 = 1'b0; addr6 = a; in6 = d;
        @(posedge clk); #1;
        load6 = 1'b0; rd6 = 1'b0;
        if (ld && a < 6) m6[a] = d;
        exp_v6 = rd;
        if (rd) begin
            if (a < 6) exp_out6 = m6[a];
            else exp_out6 = '0;
        end
    endtask

    // Counts edges until busy8 and busy6 drop; bounded so a stuck sweep cannot hang.
    task automatic sweep_len(output int n8, output int n6, output logic v_seen);
        n8 = 0; n6 = 0; v_seen = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (valid8 || valid6) v_seen = 1'b1;
            if (n8 == 0 && !busy8) n8 = k;
            if (n6 == 0 && !busy6) n6 = k;
            if (n8 != 0 && n6 != 0) break;
        end
    endtask

    task automatic test_reset();
        int n8, n6;
        logic v_seen;
        rst_n = 1'b0;
        #12;
        checks++;
        if (out8 !== 16'h0 || valid8 !== 1'b0 || busy8 !== 1'b1) begin
            errors++;
            $display("FAIL reset_d8: out=%h valid=%b busy=%b, required out=0000 valid=0 busy=1",
                     out8, valid8, busy8);
        end
        checks++;
        if (out6 !== 16'h0 || valid6 !== 1'b0 || busy6 !== 1'b1) begin
            errors++;
            $display("FAIL reset_d6: out=%h valid=%b busy=%b, required out=0000 valid=0 busy=1",
                     out6, valid6, busy6);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sweep_len(n8, n6, v_seen);
        model_reset();
        checks++;
        if (n8 != 8) begin
            errors++;
            $display("FAIL sweep_len_d8: busy cycles=%0d, required 8", n8);
        end
        checks++;
        if (n6 != 6) begin
            errors++;
            $display("FAIL sweep_len_d6: busy cycles=%0d, required 6", n6);
        end
        checks++;
        if (v_seen !== 1'b0) begin
            errors++;
            $display("FAIL sweep_valid: out_valid=1 seen during sweep, required 0");
        end
    endtask

    task automatic test_cleared_reads();
        for (int a = 0; a < 8; a++) begin
            op8(1'b0, 1'b1, 1'b0, 3'(a), 16'hDEAD);
            checks++;
            if (out8 !== 16'h0 || valid8 !== 1'b1) begin
                errors++;
                $display("FAIL cleared_read[%0d]: out=%h valid=%b, required out=0000 valid=1",
                         a, out8, valid8);
            end
        end
    endtask

    task automatic test_write_read();
        op8(1'b1, 1'b0, 1'b0, 3'd3, 16'hA5A5);
        checks++;
        if (valid8 !== 1'b0) begin
            errors++;
            $display("FAIL write_no_valid: valid=%b, required 0", valid8);
        end
        op8(1'b0, 1'b1, 1'b0, 3'd3, 16'h0000);
        checks++;
        if (out8 !== 16'hA5A5 || valid8 !== 1'b1) begin
            errors++;
            $display("FAIL write_read: out=%h valid=%b, required out=a5a5 valid=1", out8, valid8);
        end
    endtask

    task automatic test_write_first();
        op8(1'b1, 1'b1, 1'b0, 3'd5, 16'h1234);
        checks++;
        if (out8 !== 16'h1234 || valid8 !== 1'b1) begin
            errors++;
            $display("FAIL write_first: out=%h valid=%b, required out=1234 valid=1", out8, valid8);
        end
        op8(1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
        checks++;
        if (out8 !== 16'h1234 || valid8 !== 1'b0) begin
            errors++;
            $display("FAIL hold: out=%h valid=%b, required out=1234 valid=0", out8, valid8);
        end
    endtask

    task automatic test_out_of_range();
        for (int a = 0; a < 6; a++) op6(1'b1, 1'b0, 3'(a), 16'(16'h0100 + a));
        op6(1'b1, 1'b0, 3'd6, 16'hFFFF);
        op6(1'b0, 1'b1, 3'd6, 16'h0);
        checks++;
        if (out6 !== 16'h0 || valid6 !== 1'b1) begin
            errors++;
            $display("FAIL oob_read: out=%h valid=%b, required out=0000 valid=1", out6, valid6);
        end
        op6(1'b1, 1'b1, 3'd7, 16'hBEEF);
        checks++;
        if (out6 !== 16'h0 || valid6 !== 1'b1) begin
            errors++;
            $display("FAIL oob_bypass: out=%h valid=%b, required out=0000 valid=1", out6, valid6);
        end
        for (int a = 0; a < 6; a++) begin
            op6(1'b0, 1'b1, 3'(a), 16'h0);
            checks++;
            if (out6 !== exp_out6 || valid6 !== 1'b1) begin
                errors++;
                $display("FAIL oob_intact[%0d]: out=%h valid=%b, required out=%h valid=1",
                         a, out6, valid6, exp_out6);
            end
        end
    endtask

    task automatic test_random();
        logic ld, rd;
        logic [2:0] a;
        logic [15:0] d;
        for (int i = 0; i < 150; i++) begin
            ld = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            a  = 3'($urandom_range(0, 7));
            d  = 16'($urandom);
            op8(ld, rd, 1'b0, a, d);
            checks++;
            if (out8 !== exp_out8 || valid8 !== exp_v8) begin
                errors++;
                $display("FAIL rand_d8[%0d]: out=%h valid=%b, required out=%h valid=%b",
                         i, out8, valid8, exp_out8, exp_v8);
            end
`ifdef RAM_PARITY_EN
            checks++;
            if (perr8 !== 1'b0) begin
                errors++;
                $display("FAIL rand_perr[%0d]: parity_err=%b, required 0", i, perr8);
            end
`endif
        end
        for (int i = 0; i < 100; i++) begin
            ld = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            a  = 3'($urandom_range(0, 7));
            d  = 16'($urandom);
            op6(ld, rd, a, d);
            checks++;
            if (out6 !== exp_out6 || valid6 !== exp_v6) begin
                errors++;
                $display("FAIL rand_d6[%0d]: out=%h valid=%b, required out=%h valid=%b",
                         i, out6, valid6, exp_out6, exp_v6);
            end
        end
    endtask

    task automatic test_clr();
        int n8, n6;
        logic v_seen;
        logic [15:0] held;
        for (int a = 0; a < 8; a++) op8(1'b1, 1'b0, 1'b0, 3'(a), 16'h00FF);
        op8(1'b0, 1'b1, 1'b0, 3'd2, 16'h0);
        held = exp_out8;
        op8(1'b1, 1'b1, 1'b1, 3'd2, 16'h1111);
        checks++;
        if (busy8 !== 1'b1 || valid8 !== 1'b0 || out8 !== held) begin
            errors++;
            $display("FAIL clr_start: busy=%b valid=%b out=%h, required busy=1 valid=0 out=%h",
                     busy8, valid8, out8, held);
        end
        sweep_len(n8, n6, v_seen);
        checks++;
        if (n8 != 8) begin
            errors++;
            $display("FAIL clr_len: busy cycles=%0d, required 8", n8);
        end
        for (int a = 0; a < 8; a++) begin
            op8(1'b0, 1'b1, 1'b0, 3'(a), 16'h0);
            checks++;
            if (out8 !== 16'h0 || valid8 !== 1'b1) begin
                errors++;
                $display("FAIL clr_read[%0d]: out=%h valid=%b, required out=0000 valid=1",
                         a, out8, valid8);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n8, n6;
        logic v_seen;
        op8(1'b1, 1'b1, 1'b0, 3'd4, 16'h7E7E);
        op8(1'b0, 1'b0, 1'b1, 3'd0, 16'h0);
        for (int k = 0; k < 3; k++) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out8 !== 16'h0 || valid8 !== 1'b0 || busy8 !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: out=%h valid=%b busy=%b, required out=0000 valid=0 busy=1",
                     out8, valid8, busy8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sweep_len(n8, n6, v_seen);
        model_reset();
        checks++;
        if (n8 != 8 || n6 != 6) begin
            errors++;
            $display("FAIL mid_reset_len: busy cycles d8=%0d d6=%0d, required 8 and 6", n8, n6);
        end
    endtask

`ifdef RAM_PARITY_EN
    task automatic test_parity();
        op8(1'b1, 1'b0, 1'b0, 3'd1, 16'h0001);
        @(negedge clk);
        d8.mem[1][0] = 1'b0;
        m8[1] = 16'h0000;
        op8(1'b0, 1'b1, 1'b0, 3'd1, 16'h0);
        checks++;
        if (perr8 !== 1'b1 || out8 !== 16'h0000) begin
            errors++;
            $display("FAIL parity_err: perr=%b out=%h, required perr=1 out=0000", perr8, out8);
        end
        op8(1'b0, 1'b1, 1'b0, 3'd6, 16'h0);
        checks++;
        if (perr8 !== 1'b0 || out8 !== 16'h0000) begin
            errors++;
            $display("FAIL parity_clean: perr=%b out=%h, required perr=0 out=0000", perr8, out8);
        end
    endtask
`endif

    initial begin
        in8 = '0; addr8 = '0; load8 = 1'b0; rd8 = 1'b0; clr8 = 1'b0;
        in6 = '0; addr6 = '0; load6 = 1'b0; rd6 = 1'b0; clr6 = 1'b0;
        model_reset();
        test_reset();
        test_cleared_reads();
        test_write_read();
        test_write_first();
        test_out_of_range();
        test_random();
        test_clr();
        test_reset_mid();
`ifdef RAM_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
